tile_pack_buffer: RTL and testbench
===================================

TILE_PACK_BUFFER -- requirements
Module: tile_pack_buffer

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- DW_IN, 8, input element width in bits
- RATIO, 2, elements packed per output word
- ROWS, 8, tile rows
- COLS, 8, tile columns (integer multiple of RATIO)
- AW, 18, output address width
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  write one element into fill bank
- in_row  in  clog2(ROWS)  element row index
- in_col  in  clog2(COLS)  element column index
- in_data  in  DW_IN  element value
- bank_swap  in  1  fill bank complete, exchange banks
- start  in  1  begin draining drain bank
- base_addr  in  AW  first output address
- w_ready  in  1  downstream accepts current word
- w_en  out  1  output word valid (SRAM write enable)
- w_addr  out  AW  output word address
- w_data  out  DW_IN*RATIO  packed output word
- fill_bank  out  1  bank currently receiving writes
- busy  out  1  transfer in progress
- done  out  1  one-cycle transfer-complete pulse
- err  out  1  one-cycle rejected-command pulse

Function
REQ-003 Storage SHALL be two banks of ROWS*COLS elements; element (r,c) at offset r*COLS+c.
REQ-004 When in_valid=1 and the index is in range, in_data SHALL be written to bank fill_bank on the clock edge; out-of-range indices SHALL be ignored.
REQ-005 Drain bank SHALL always be the bank not equal to fill_bank; fill writes never touch the drain bank.
REQ-006 bank_swap with busy=0 SHALL toggle fill_bank on the clock edge; bank_swap with busy=1 SHALL be ignored and pulse err for one cycle.
REQ-007 in_valid and bank_swap in the same cycle: the write SHALL land in the pre-swap fill bank.
REQ-008 FSM states SHALL be IDLE, XFER, DONE; busy=1 in XFER and DONE.
REQ-009 IDLE: start=1 -> XFER, latch base_addr, word index k=0; start=1 while busy -> ignored, err pulse.
REQ-010 XFER: w_en=1, w_addr=latched base+k (mod 2^AW), w_data=word k of drain bank.
REQ-011 Word k SHALL contain row r=k/(COLS/RATIO), columns g*RATIO..g*RATIO+RATIO-1 with g=k mod (COLS/RATIO); lowest column in the MSB slice.
REQ-012 k SHALL advance only on cycles with w_en=1 and w_ready=1; w_en, w_addr, w_data SHALL stay stable while w_ready=0.
REQ-013 Acceptance of word ROWS*COLS/RATIO-1 SHALL move XFER -> DONE; DONE asserts done=1 for exactly one cycle, then -> IDLE.
REQ-014 Throughput SHALL be one word per cycle with w_ready held high; start-to-first-w_en latency one cycle.
REQ-015 A new start SHALL be accepted in the cycle after done (IDLE).

Reset
REQ-016 reset=0 SHALL asynchronously force IDLE, k=0, fill_bank=0, w_en=0, w_addr=0, busy=0, done=0, err=0; w_data unconstrained.
REQ-017 Memory contents SHALL NOT be reset.
REQ-018 reset asserted mid-XFER SHALL abort the transfer with no done pulse; no further w_en until a new start.

Verification
REQ-019 Fill bank0 with element (r,c)=r*8+c, swap, start with base 0x100, w_ready=1 -> 32 words, word0=0x0001 @0x100, word31=0x3E3F @0x11F, done pulse one cycle after last accept.
REQ-020 Same transfer with w_ready toggling every other cycle -> identical 32 words/addresses, outputs stable during stalls, 63 cycles start-to-done.
REQ-021 During drain of bank1, write 64 new elements to bank0 and issue bank_swap mid-transfer -> drained data unchanged, err pulses once, fill_bank stays 0.
REQ-022 base_addr=0x3FFFE -> addresses 0x3FFFE, 0x3FFFF, 0x00000... wrap.
REQ-023 reset low at word 10 -> w_en=0 immediately, busy=0, no done; subsequent start replays from word 0.

Source files
------------

// File: rtl/tile_pack_buffer.sv
// Double-buffered tile store. One bank is filled element by element while the
// other bank is drained as packed words, RATIO elements per word, in row-major
// order. The lowest column of each group lands in the most significant slice.
module tile_pack_buffer #(
    parameter int DW_IN = 8,
    parameter int RATIO = 2,
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int AW    = 18
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [$clog2(ROWS)-1:0]   in_row,
    input  logic [$clog2(COLS)-1:0]   in_col,
    input  logic [DW_IN-1:0]          in_data,
    input  logic                      bank_swap,
    input  logic                      start,
    input  logic [AW-1:0]             base_addr,
    input  logic                      w_ready,
    output logic                      w_en,
    output logic [AW-1:0]             w_addr,
    output logic [DW_IN*RATIO-1:0]    w_data,
    output logic                      fill_bank,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int DEPTH  = ROWS * COLS;
    localparam int NWORDS = DEPTH / RATIO;
    localparam int IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int KW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DONE
    } state_t;

    state_t            state;
    logic [KW-1:0]     k;
    logic [DW_IN-1:0]  mem [2][DEPTH];

    logic [31:0]       row_ext;
    logic [31:0]       col_ext;
    logic              wr_ok;
    logic [IW-1:0]     wr_idx;
    logic [IW-1:0]     rd_idx;
    logic              drain_bank;
    logic              accept;
    logic              last_word;

    // Index arithmetic is done at 32 bits so non-power-of-two tiles range-check correctly
    assign row_ext    = 32'(in_row);
    assign col_ext    = 32'(in_col);
    assign wr_ok      = in_valid && (row_ext < ROWS) && (col_ext < COLS);
    assign wr_idx     = IW'(row_ext * COLS + col_ext);
    assign drain_bank = ~fill_bank;
    assign accept     = w_en && w_ready;
    assign last_word  = (k == KW'(NWORDS - 1));

    // Element writes go only to the fill bank; storage carries no reset
    always_ff @(posedge clock) begin
        if (wr_ok) begin
            mem[fill_bank][wr_idx] <= in_data;
        end
    end

    // Word k covers elements k*RATIO .. k*RATIO+RATIO-1, since COLS is a multiple
    // of RATIO this equals row k/(COLS/RATIO), group k mod (COLS/RATIO)
    always_comb begin
        w_data = '0;
        rd_idx = '0;
        for (int i = 0; i < RATIO; i++) begin
            rd_idx = IW'(32'(k) * RATIO + i);
            w_data[(RATIO-1-i)*DW_IN +: DW_IN] = mem[drain_bank][rd_idx];
        end
    end

    // Bank exchange is only honoured while no transfer is running
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fill_bank <= 1'b0;
        end else if (bank_swap && !busy) begin
            fill_bank <= ~fill_bank;
        end
    end

    // Drain sequencer: IDLE -> XFER (one word per accepted cycle) -> DONE -> IDLE
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            k      <= '0;
            w_en   <= 1'b0;
            w_addr <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= busy && (start || bank_swap);
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= XFER;
                        k      <= '0;
                        w_addr <= base_addr;
                        w_en   <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                XFER: begin
                    if (accept) begin
                        if (last_word) begin
                            state <= DONE;
                            w_en  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            k      <= k + 1'b1;
                            w_addr <= w_addr + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    k     <= '0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    w_en  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tile_pack_buffer.sv
// Bench for tile_pack_buffer: command table, directed drains, reset abort and
// randomized fills/drains against a tile-level reference model.
module tb_tile_pack_buffer;

    localparam int DW  = 8;
    localparam int RAT = 2;
    localparam int NR  = 8;
    localparam int NC  = 8;
    localparam int AW  = 18;
    localparam int WPR = NC / RAT;
    localparam int NW  = NR * NC / RAT;
    localparam int WW  = DW * RAT;

    logic           clock;
    logic           reset;
    logic           in_valid;
    logic [2:0]     in_row;
    logic [2:0]     in_col;
    logic [DW-1:0]  in_data;
    logic           bank_swap;
    logic           start;
    logic [AW-1:0]  base_addr;
    logic           w_ready;
    logic           w_en;
    logic [AW-1:0]  w_addr;
    logic [WW-1:0]  w_data;
    logic           fill_bank;
    logic           busy;
    logic           done;
    logic           err;

    tile_pack_buffer #(
        .DW_IN(DW), .RATIO(RAT), .ROWS(NR), .COLS(NC), .AW(AW)
    ) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_row(in_row), .in_col(in_col), .in_data(in_data),
        .bank_swap(bank_swap), .start(start), .base_addr(base_addr),
        .w_ready(w_ready), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
        .fill_bank(fill_bank), .busy(busy), .done(done), .err(err)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: two tiles indexed [bank][row][col] plus the fill bank
    logic [DW-1:0] mm [2][NR][NC];
    bit            mfill;

    typedef struct packed {
        logic          sw;
        logic          st;
        logic          rdy;
        logic [AW-1:0] base;
        logic          e_fill;
        logic          e_busy;
        logic          e_err;
        logic          e_wen;
        logic [AW-1:0] e_addr;
        logic          e_done;
    } vec_t;

    vec_t tbl [9];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic vec_t mk(input logic sw, input logic st, input logic rdy,
                                input logic [AW-1:0] b, input logic ef, input logic eb,
                                input logic ee, input logic ew, input logic [AW-1:0] ea,
                                input logic ed);
        vec_t v;
        v.sw = sw; v.st = st; v.rdy = rdy; v.base = b;
        v.e_fill = ef; v.e_busy = eb; v.e_err = ee; v.e_wen = ew;
        v.e_addr = ea; v.e_done = ed;
        return v;
    endfunction

    // Word k of bank b: row k/WPR, columns g*RAT.., first column most significant
    function automatic logic [WW-1:0] model_word(input bit b, input int kk);
        int r;
        int g;
        logic [WW-1:0] w;
        r = kk / WPR;
        g = kk % WPR;
        w = '0;
        for (int i = 0; i < RAT; i++) begin
            w = (w << DW) | WW'(mm[b][r][g*RAT+i]);
        end
        return w;
    endfunction

    task automatic write_elem(input int r, input int c, input logic [DW-1:0] d, input bit sw);
        in_valid  = 1'b1;
        in_row    = 3'(r);
        in_col    = 3'(c);
        in_data   = d;
        bank_swap = sw;
        mm[mfill][r][c] = d;
        if (sw) mfill = !mfill;
        tick;
        in_valid  = 1'b0;
        bank_swap = 1'b0;
    endtask

    task automatic do_swap;
        bank_swap = 1'b1;
        tick;
        bank_swap = 1'b0;
        mfill = !mfill;
        chk("swap_fill", 64'(fill_bank), 64'(mfill));
        chk("swap_err", 64'(err), 64'(0));
    endtask

    task automatic apply_reset;
        reset = 1'b0;
        #2;
        reset = 1'b1;
        mfill = 1'b0;
    endtask

    // mode: 0 ready always, 1 ready every other cycle, 2 random, 3 one cycle in three
    task automatic run_xfer(input logic [AW-1:0] base, input int mode, input bit intf,
                            output logic [WW-1:0] fw, output logic [AW-1:0] fa,
                            output logic [WW-1:0] lw, output logic [AW-1:0] la,
                            output int cyc);
        logic [WW-1:0] exp_w [NW];
        logic [DW-1:0] d;
        bit drain;
        bit rdy;
        int k;
        int i;
        int errs;
        drain = !mfill;
        for (int j = 0; j < NW; j++) exp_w[j] = model_word(drain, j);
        fw = '0; fa = '0; lw = '0; la = '0;
        start     = 1'b1;
        base_addr = base;
        w_ready   = 1'b0;
        tick;
        start     = 1'b0;
        base_addr = AW'($urandom);
        chk("start_busy", 64'(busy), 64'(1));
        k = 0;
        i = 0;
        errs = 0;
        while (k < NW && i < 1000) begin
            chk("xfer_wen", 64'(w_en), 64'(1));
            chk("xfer_addr", 64'(w_addr), 64'(AW'(base + AW'(k))));
            chk("xfer_data", 64'(w_data), 64'(exp_w[k]));
            if (k == 0) begin fw = w_data; fa = w_addr; end
            if (k == NW - 1) begin lw = w_data; la = w_addr; end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (i % 2 == 0);
                2:       rdy = ($urandom_range(0, 1) == 1);
                default: rdy = (i % 3 == 0);
            endcase
            w_ready   = rdy;
            in_valid  = 1'b0;
            bank_swap = 1'b0;
            if (intf && i < NR * NC) begin
                d = DW'($urandom);
                in_valid = 1'b1;
                in_row   = 3'(i / NC);
                in_col   = 3'(i % NC);
                in_data  = d;
                mm[mfill][i / NC][i % NC] = d;
            end
            if (intf && i == 10) bank_swap = 1'b1;
            tick;
            i++;
            if (rdy) k++;
            if (err) errs++;
            if (k < NW) chk("xfer_no_done", 64'(done), 64'(0));
        end
        in_valid  = 1'b0;
        bank_swap = 1'b0;
        cyc = i;
        if (k < NW) chk("xfer_timeout", 64'(k), 64'(NW));
        chk("done_pulse", 64'(done), 64'(1));
        chk("done_wen", 64'(w_en), 64'(0));
        chk("done_busy", 64'(busy), 64'(1));
        chk("xfer_errs", 64'(errs), 64'(intf ? 1 : 0));
        chk("xfer_fill", 64'(fill_bank), 64'(mfill));
        tick;
        chk("after_done", 64'(done), 64'(0));
        chk("after_busy", 64'(busy), 64'(0));
        chk("after_wen", 64'(w_en), 64'(0));
    endtask

    initial begin
        logic [WW-1:0] fw;
        logic [WW-1:0] lw;
        logic [AW-1:0] fa;
        logic [AW-1:0] la;
        int cyc;
        int n;

        reset = 1'b1;
        in_valid = 1'b0; in_row = '0; in_col = '0; in_data = '0;
        bank_swap = 1'b0; start = 1'b0; base_addr = '0; w_ready = 1'b0;
        mfill = 1'b0;
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < NR; r++)
                for (int c = 0; c < NC; c++) mm[b][r][c] = '0;

        tbl[0] = mk(1, 0, 0, 18'h0,   1, 0, 0, 0, 18'h0,  0);
        tbl[1] = mk(1, 0, 0, 18'h0,   0, 0, 0, 0, 18'h0,  0);
        tbl[2] = mk(0, 1, 0, 18'h55,  0, 1, 0, 1, 18'h55, 0);
        tbl[3] = mk(1, 0, 0, 18'h0,   0, 1, 1, 1, 18'h55, 0);
        tbl[4] = mk(0, 0, 1, 18'h0,   0, 1, 0, 1, 18'h56, 0);
        tbl[5] = mk(0, 1, 0, 18'h200, 0, 1, 1, 1, 18'h56, 0);
        tbl[6] = mk(1, 1, 0, 18'h200, 0, 1, 1, 1, 18'h56, 0);
        tbl[7] = mk(0, 0, 0, 18'h0,   0, 1, 0, 1, 18'h56, 0);
        tbl[8] = mk(0, 0, 1, 18'h0,   0, 1, 0, 1, 18'h57, 0);

        #2 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_wen", 64'(w_en), 64'(0));
        chk("rst_addr", 64'(w_addr), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_fill", 64'(fill_bank), 64'(0));
        reset = 1'b1;

        // Command table: swaps, start, commands while busy, stalls
        for (int t = 0; t < 9; t++) begin
            bank_swap = tbl[t].sw;
            start     = tbl[t].st;
            w_ready   = tbl[t].rdy;
            base_addr = tbl[t].base;
            tick;
            chk($sformatf("tbl%0d_fill", t), 64'(fill_bank), 64'(tbl[t].e_fill));
            chk($sformatf("tbl%0d_busy", t), 64'(busy), 64'(tbl[t].e_busy));
            chk($sformatf("tbl%0d_err", t), 64'(err), 64'(tbl[t].e_err));
            chk($sformatf("tbl%0d_wen", t), 64'(w_en), 64'(tbl[t].e_wen));
            chk($sformatf("tbl%0d_addr", t), 64'(w_addr), 64'(tbl[t].e_addr));
            chk($sformatf("tbl%0d_done", t), 64'(done), 64'(tbl[t].e_done));
        end
        bank_swap = 1'b0; start = 1'b0; w_ready = 1'b0;
        apply_reset;
        chk("tbl_rst_busy", 64'(busy), 64'(0));
        chk("tbl_rst_wen", 64'(w_en), 64'(0));
        tick;

        // Ramp fill of bank 0; final write coincides with the swap
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                write_elem(r, c, DW'(r * 8 + c), (r == NR - 1 && c == NC - 1));
        chk("ramp_fill", 64'(fill_bank), 64'(1));
        run_xfer(18'h100, 0, 0, fw, fa, lw, la, cyc);
        chk("ramp_w0", 64'(fw), 64'(16'h0001));
        chk("ramp_a0", 64'(fa), 64'(18'h100));
        chk("ramp_w31", 64'(lw), 64'(16'h3E3F));
        chk("ramp_a31", 64'(la), 64'(18'h11F));
        chk("ramp_cycles", 64'(cyc), 64'(32));

        // Same drain with w_ready toggling, started right after done
        run_xfer(18'h100, 1, 0, fw, fa, lw, la, cyc);
        chk("stall_w0", 64'(fw), 64'(16'h0001));
        chk("stall_w31", 64'(lw), 64'(16'h3E3F));
        chk("stall_a31", 64'(la), 64'(18'h11F));
        chk("stall_cycles", 64'(cyc), 64'(63));

        // Fill bank 1, drain it while refilling bank 0 and swapping mid-transfer
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                write_elem(r, c, DW'($urandom), 0);
        do_swap;
        run_xfer(18'h40, 3, 1, fw, fa, lw, la, cyc);
        chk("intf_fill", 64'(fill_bank), 64'(0));

        // Drain the refilled bank 0 with an address that wraps
        do_swap;
        run_xfer(18'h3FFFE, 2, 0, fw, fa, lw, la, cyc);
        chk("wrap_a0", 64'(fa), 64'(18'h3FFFE));
        chk("wrap_a31", 64'(la), 64'(18'h1D));

        // Reset during word 10, then replay from word 0
        do_swap;
        start = 1'b1; base_addr = 18'h80; w_ready = 1'b1;
        tick;
        start = 1'b0;
        repeat (10) tick;
        chk("abort_addr", 64'(w_addr), 64'(18'h8A));
        #2 reset = 1'b0;
        #1;
        chk("abort_wen", 64'(w_en), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        chk("abort_addr0", 64'(w_addr), 64'(0));
        chk("abort_fill", 64'(fill_bank), 64'(0));
        tick;
        reset = 1'b1;
        mfill = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick;
            chk("abort_idle_wen", 64'(w_en), 64'(0));
            chk("abort_idle_done", 64'(done), 64'(0));
        end
        w_ready = 1'b0;
        run_xfer(18'h80, 0, 0, fw, fa, lw, la, cyc);
        chk("replay_a0", 64'(fa), 64'(18'h80));

        // Random partial refills, random swaps and randomly stalled drains
        for (int it = 0; it < 4; it++) begin
            n = int'($urandom_range(8, 40));
            for (int j = 0; j < n; j++) begin
                write_elem(int'($urandom_range(0, NR - 1)), int'($urandom_range(0, NC - 1)),
                           DW'($urandom), (j == n - 1) && ($urandom_range(0, 1) == 1));
                if (j < n - 1 && $urandom_range(0, 7) == 0) do_swap;
            end
            chk("rand_fill", 64'(fill_bank), 64'(mfill));
            run_xfer(AW'($urandom), 2, 0, fw, fa, lw, la, cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
